// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM stage and a debug port.
// Define DMEM_ARB_PERF_EN to add saturating stall/debug-access counters (stall_cnt_o, dbg_cnt_o).
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  dbg_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT - 1);

  state_t            state, state_next;
  logic              owner_dbg;
  logic              last_gnt_dbg;
  logic [LW-1:0]     lat_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              grant;
  logic              pick_dbg;
  logic              last_cycle;

  assign last_cycle = (lat_cnt == '0);

  // Every combinational output is forced low during reset so an interrupted access never strobes memory.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    pick_dbg    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    dbg_valid_o = 1'b0;
    dbg_gnt_o   = 1'b0;
    cpu_stall_o = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          grant      = 1'b1;
          pick_dbg   = dbg_req_i & (~cpu_req_i | ~last_gnt_dbg);
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q & last_cycle;
        if (last_cycle) state_next = DONE;
      end
      DONE: begin
        dbg_valid_o = owner_dbg;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    dbg_gnt_o   = grant & pick_dbg;
    cpu_stall_o = cpu_req_i & ~((state == DONE) & ~owner_dbg);
    if (rst_i) begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      dbg_valid_o = 1'b0;
      dbg_gnt_o   = 1'b0;
      cpu_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      owner_dbg    <= 1'b0;
      last_gnt_dbg <= 1'b1;
      lat_cnt      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner_dbg    <= pick_dbg;
        last_gnt_dbg <= pick_dbg;
        lat_cnt      <= LAT_LAST;
        we_q         <= pick_dbg ? dbg_we_i    : cpu_we_i;
        addr_q       <= pick_dbg ? dbg_addr_i  : cpu_addr_i;
        wdata_q      <= pick_dbg ? dbg_wdata_i : cpu_wdata_i;
      end else if (state == ACCESS && !last_cycle) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      // Read data is registered at the end of the final access cycle so it is presented during DONE and held afterwards.
      if (state == ACCESS && last_cycle) begin
        if (owner_dbg) dbg_rdata_q <= mem_rdata_i;
        else           cpu_rdata_q <= we_q ? '0 : mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] stall_cnt, dbg_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      dbg_cnt   <= '0;
    end else begin
      if (cpu_stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (dbg_valid_o && dbg_cnt != '1)   dbg_cnt   <= dbg_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign dbg_cnt_o   = dbg_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: random CPU/debug traffic against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int LAT = 2;
  localparam int N   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_valid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt, dbg_cnt;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rdata_o(dbg_rdata), .dbg_valid_o(dbg_valid),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .stall_cnt_o(stall_cnt), .dbg_cnt_o(dbg_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: combinational read, write on the strobe edge, indexed by word address bits [5:2].
  logic [31:0] dut_mem [16];
  logic [31:0] ref_mem [16];
  assign mem_rdata = dut_mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dut_mem[mem_addr[5:2]] <= mem_wdata;

  typedef struct {
    bit          we;
    logic [31:0] addr, wdata, rdata;
    int          gap, arr, gnt, done;
  } op_t;

  typedef struct {
    int          cycle;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  op_t  cpu_ops[N];
  op_t  dbg_ops[N];
  exp_t cpu_q[$];
  exp_t dbg_q[$];
  int   gnt_q[$];

  int total = 0, passed = 0;
  int we_cnt = 0, en_cnt = 0;
  bit mon_en = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one operation on a port: raise the request at its arrival cycle, hold until its predicted completion.
  task automatic applyStimulus(input bit is_dbg, input int idx);
    op_t  op;
    exp_t e;
    op = is_dbg ? dbg_ops[idx] : cpu_ops[idx];
    while (cyc < op.arr) begin @(posedge clk); #1; end
    e.cycle = op.done;
    e.rdata = op.rdata;
    e.chk   = is_dbg ? !op.we : 1'b1;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = op.we; dbg_addr = op.addr; dbg_wdata = op.wdata;
      dbg_q.push_back(e);
      gnt_q.push_back(op.gnt);
    end else begin
      cpu_req = 1'b1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.wdata;
      cpu_q.push_back(e);
    end
    while (cyc < op.done) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    if (is_dbg) dbg_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  // Reference: serialised accesses of LAT+2 cycles each, ties go to the port not granted last.
  int exp_writes, exp_stall, last_done;
  task automatic build_schedule(input int base);
    int ci, di, cn, dn, ca, da, t;
    bit last_dbg, pick_dbg;
    op_t op;
    ci = 0; di = 0; t = 0;
    last_dbg = 1'b1;
    cn = base + cpu_ops[0].gap;
    dn = base + dbg_ops[0].gap;
    last_done = base; exp_writes = 0; exp_stall = 0;
    while (ci < N || di < N) begin
      ca = (ci < N) ? cn : 32'h3fff_ffff;
      da = (di < N) ? dn : 32'h3fff_ffff;
      if (ca < da) t = (ca > t) ? ca : t;
      else         t = (da > t) ? da : t;
      pick_dbg = (da <= t) && (!(ca <= t) || !last_dbg);
      op = pick_dbg ? dbg_ops[di] : cpu_ops[ci];
      op.arr  = pick_dbg ? dn : cn;
      op.gnt  = t;
      op.done = t + LAT + 1;
      if (op.we) begin
        ref_mem[op.addr[5:2]] = op.wdata;
        op.rdata = 32'h0;
        exp_writes++;
      end else begin
        op.rdata = ref_mem[op.addr[5:2]];
      end
      if (pick_dbg) begin
        dbg_ops[di] = op; di++;
        if (di < N) dn = op.done + 1 + dbg_ops[di].gap;
      end else begin
        exp_stall += op.done - op.arr;
        cpu_ops[ci] = op; ci++;
        if (ci < N) cn = op.done + 1 + cpu_ops[ci].gap;
      end
      last_dbg  = pick_dbg;
      last_done = op.done;
      t = op.done + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (mon_en) begin
      if (mem_we) we_cnt++;
      if (mem_en) en_cnt++;
      if (cpu_req && !cpu_stall) begin
        checkOutput("cpu_done_expected", 64'(cpu_q.size() != 0), 64'd1);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          checkOutput("cpu_done_cycle", 64'(cyc), 64'(e.cycle));
          checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
        end
      end
      if (dbg_gnt) begin
        checkOutput("dbg_gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
        if (gnt_q.size() != 0) begin
          g = gnt_q.pop_front();
          checkOutput("dbg_gnt_cycle", 64'(cyc), 64'(g));
        end
      end
      if (dbg_valid) begin
        checkOutput("dbg_valid_expected", 64'(dbg_q.size() != 0), 64'd1);
        if (dbg_q.size() != 0) begin
          e = dbg_q.pop_front();
          checkOutput("dbg_valid_cycle", 64'(cyc), 64'(e.cycle));
          if (e.chk) checkOutput("dbg_rdata", 64'(dbg_rdata), 64'(e.rdata));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    for (int i = 0; i < N; i++) begin
      cpu_ops[i].we = 1'($urandom_range(0, 1));
      cpu_ops[i].addr = $urandom; cpu_ops[i].wdata = $urandom;
      cpu_ops[i].gap = (i < 3 || $urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 4));
      dbg_ops[i].we = 1'($urandom_range(0, 1));
      dbg_ops[i].addr = $urandom; dbg_ops[i].wdata = $urandom;
      dbg_ops[i].gap = (i < 3 || $urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 4));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall_forced_low", 64'(cpu_stall), 64'd0);
    checkOutput("reset_dbg_gnt", 64'(dbg_gnt), 64'd0);
    checkOutput("reset_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    checkOutput("idle_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("idle_cpu_rdata", 64'(cpu_rdata), 64'd0);
    checkOutput("idle_dbg_rdata", 64'(dbg_rdata), 64'd0);
    checkOutput("idle_dbg_valid", 64'(dbg_valid), 64'd0);

    @(posedge clk); #1;
    build_schedule(cyc + 2);
    mon_en = 1'b1;
    fork
      begin for (int i = 0; i < N; i++) applyStimulus(1'b0, i); end
      begin for (int j = 0; j < N; j++) applyStimulus(1'b1, j); end
    join
    while (cyc < last_done + 3) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    checkOutput("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
    checkOutput("dbg_queue_drained", 64'(dbg_q.size()), 64'd0);
    checkOutput("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    checkOutput("mem_we_cycles", 64'(we_cnt), 64'(exp_writes));
    checkOutput("mem_en_cycles", 64'(en_cnt), 64'(2 * N * LAT));
    for (int i = 0; i < 16; i++) checkOutput($sformatf("mem_word_%0d", i), 64'(dut_mem[i]), 64'(ref_mem[i]));
`ifdef DMEM_ARB_PERF_EN
    checkOutput("perf_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    checkOutput("perf_dbg_cnt", 64'(dbg_cnt), 64'(N));
`endif

    // Reset during the first access cycle of a CPU write must leave memory untouched.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = ~ref_mem[2];
    @(negedge clk);
    checkOutput("rstw_stall_at_grant", 64'(cpu_stall), 64'd1);
    checkOutput("rstw_we_at_grant", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstw_stall_in_reset", 64'(cpu_stall), 64'd0);
    checkOutput("rstw_we_in_reset", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("rstw_mem_en_after", 64'(mem_en), 64'd0);
    checkOutput("rstw_mem_we_after", 64'(mem_we), 64'd0);
    checkOutput("rstw_mem_addr_after", 64'(mem_addr), 64'd0);
    checkOutput("rstw_mem_wdata_after", 64'(mem_wdata), 64'd0);
    checkOutput("rstw_cpu_rdata_after", 64'(cpu_rdata), 64'd0);
    checkOutput("rstw_dbg_rdata_after", 64'(dbg_rdata), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstw_mem_unchanged", 64'(dut_mem[2]), 64'(ref_mem[2]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
